// File: rtl/ir_receiver.sv
// ir_receiver
//   Receiving end of the car-control IR link. The raw carrier-modulated IR
//   input is synchronised and edge-detected, carrier rising edges are counted
//   per burst, and each burst is classified by its pulse count as a start
//   burst, a 1 bit, a 0 bit or a glitch. A frame is start, car-select, then
//   the right, left, backward and forward bits. A complete frame is decoded
//   into a 4-bit command that is readable over the microprocessor bus, and it
//   raises a level interrupt.
//
// Ports
//   CLK                  system clock
//   RESET                synchronous, active-high reset
//   IR_IN                raw IR input (asynchronous to CLK)
//   BUS_ADDR[7:0]        bus address
//   BUS_DATA[7:0]        bus data; driven only during a read of our addresses
//   BUS_WE               bus write enable (0 = read)
//   BUS_INTERRUPT_RAISE  level interrupt, set per decoded frame
//   BUS_INTERRUPT_ACK    clears the interrupt
//   COMMAND[3:0]         last command: [0] right [1] left [2] back [3] fwd
//   FRAME_VALID          one-cycle strobe per decoded frame
//
// Register map
//   BASE_ADDR    read : {3'b0, NEW, COMMAND}, the read clears NEW
//                write: ignored
//   BASE_ADDR+1  read : ERR_CNT (saturating frame error count)
//                write: any value clears ERR_CNT
module ir_receiver #(
  parameter logic [7:0] BASE_ADDR     = 8'h94,
  parameter int         GAP_CYCLES    = 4000,
  parameter int         START_MIN     = 150,
  parameter int         LONG_MIN      = 35,
  parameter int         SHORT_MIN     = 15,
  parameter int         FRAME_TIMEOUT = 500000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  output logic [3:0] COMMAND,
  output logic       FRAME_VALID
);

  localparam int IDLE_MAX = (GAP_CYCLES > FRAME_TIMEOUT) ? GAP_CYCLES : FRAME_TIMEOUT;
  // One spare count so the +1 taken on the classification cycle cannot wrap.
  localparam int IDLE_W   = $clog2(IDLE_MAX + 2);

  localparam logic [IDLE_W-1:0] GAP_TH     = IDLE_W'(GAP_CYCLES);
  localparam logic [IDLE_W-1:0] TIMEOUT_TH = IDLE_W'(FRAME_TIMEOUT);
  localparam logic [7:0]        START_TH   = 8'(START_MIN);
  localparam logic [7:0]        LONG_TH    = 8'(LONG_MIN);
  localparam logic [7:0]        SHORT_TH   = 8'(SHORT_MIN);
  localparam logic [7:0]        ERR_ADDR   = BASE_ADDR + 8'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser and carrier rising-edge detect
  // ---------------------------------------------------------------------
  logic ir_s1_reg;
  logic ir_s2_reg;
  logic ir_s2_d_reg;
  logic carrier_edge;

  assign carrier_edge = ir_s2_reg & ~ir_s2_d_reg;

  // ---------------------------------------------------------------------
  // Burst / frame FSM
  // ---------------------------------------------------------------------
  state_t            state_reg,     state_next;
  logic [7:0]        pulse_cnt_reg, pulse_cnt_next;
  logic [IDLE_W-1:0] idle_cnt_reg,  idle_cnt_next;
  logic [2:0]        burst_idx_reg, burst_idx_next;
  logic [2:0]        bits_reg,      bits_next;     // right, left, backward
  logic              frame_done;
  logic              frame_err;
  logic              is_start;
  logic              is_one;
  logic              is_bit;

  assign is_start = (pulse_cnt_reg >= START_TH);
  assign is_one   = (pulse_cnt_reg >= LONG_TH);
  assign is_bit   = (pulse_cnt_reg >= SHORT_TH);

  always_comb begin
    state_next     = state_reg;
    pulse_cnt_next = pulse_cnt_reg;
    idle_cnt_next  = idle_cnt_reg;
    burst_idx_next = burst_idx_reg;
    bits_next      = bits_reg;
    frame_done     = 1'b0;
    frame_err      = 1'b0;

    case (state_reg)
      IDLE: begin
        idle_cnt_next = '0;
        if (carrier_edge) begin
          state_next     = BURST;
          pulse_cnt_next = 8'd1;
          burst_idx_next = 3'd0;
        end
      end

      BURST: begin
        if (carrier_edge) begin
          if (pulse_cnt_reg != 8'hFF) begin
            pulse_cnt_next = pulse_cnt_reg + 8'd1;
          end
          idle_cnt_next = '0;
        end else if (idle_cnt_reg == GAP_TH) begin
          // Burst has ended: classify it. The idle counter keeps running so
          // the frame timeout is measured from the last carrier edge.
          idle_cnt_next = idle_cnt_reg + 1'b1;
          if (burst_idx_reg == 3'd0) begin
            // A frame may only open with a start burst; anything else is
            // line noise and is dropped silently.
            if (is_start) begin
              burst_idx_next = 3'd1;
              state_next     = GAP;
            end else begin
              state_next = IDLE;
            end
          end else if (!is_bit) begin
            frame_err  = 1'b1;
            state_next = IDLE;
          end else if (is_start) begin
            // A fresh start burst mid-frame resynchronises the frame.
            burst_idx_next = 3'd1;
            state_next     = GAP;
          end else if (burst_idx_reg == 3'd5) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end else begin
            case (burst_idx_reg)
              3'd2:    bits_next[0] = is_one;
              3'd3:    bits_next[1] = is_one;
              3'd4:    bits_next[2] = is_one;
              default: bits_next    = bits_reg;   // index 1: car-select, value unused
            endcase
            burst_idx_next = burst_idx_reg + 3'd1;
            state_next     = GAP;
          end
        end else begin
          idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end

      GAP: begin
        if (carrier_edge) begin
          state_next     = BURST;
          pulse_cnt_next = 8'd1;
          idle_cnt_next  = '0;
        end else if (idle_cnt_reg >= TIMEOUT_TH) begin
          frame_err  = 1'b1;
          state_next = IDLE;
        end else begin
          idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic       rd_status;
  logic       rd_err;
  logic       wr_err;
  logic [7:0] bus_rdata;
  logic       new_reg;
  logic [7:0] err_cnt_reg;
  logic [3:0] command_reg;
  logic       frame_valid_reg;
  logic       irq_reg;

  assign rd_status = ~BUS_WE && (BUS_ADDR == BASE_ADDR);
  assign rd_err    = ~BUS_WE && (BUS_ADDR == ERR_ADDR);
  assign wr_err    =  BUS_WE && (BUS_ADDR == ERR_ADDR);

  always_comb begin
    bus_rdata = 8'h00;
    if (rd_status) begin
      bus_rdata = {3'b000, new_reg, command_reg};
    end else if (rd_err) begin
      bus_rdata = err_cnt_reg;
    end
  end

  assign BUS_DATA = (rd_status || rd_err) ? bus_rdata : 8'bz;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_s1_reg       <= 1'b0;
      ir_s2_reg       <= 1'b0;
      ir_s2_d_reg     <= 1'b0;
      state_reg       <= IDLE;
      pulse_cnt_reg   <= 8'd0;
      idle_cnt_reg    <= '0;
      burst_idx_reg   <= 3'd0;
      bits_reg        <= 3'd0;
      command_reg     <= 4'd0;
      frame_valid_reg <= 1'b0;
      new_reg         <= 1'b0;
      irq_reg         <= 1'b0;
      err_cnt_reg     <= 8'd0;
    end else begin
      ir_s1_reg       <= IR_IN;
      ir_s2_reg       <= ir_s1_reg;
      ir_s2_d_reg     <= ir_s2_reg;
      state_reg       <= state_next;
      pulse_cnt_reg   <= pulse_cnt_next;
      idle_cnt_reg    <= idle_cnt_next;
      burst_idx_reg   <= burst_idx_next;
      bits_reg        <= bits_next;
      frame_valid_reg <= frame_done;

      if (frame_done) begin
        command_reg <= {is_one, bits_reg};
      end

      // A completing frame wins over a clearing read or an ACK.
      if (frame_done) begin
        new_reg <= 1'b1;
      end else if (rd_status) begin
        new_reg <= 1'b0;
      end

      if (frame_done) begin
        irq_reg <= 1'b1;
      end else if (BUS_INTERRUPT_ACK) begin
        irq_reg <= 1'b0;
      end

      // A clearing write wins over a same-cycle error.
      if (wr_err) begin
        err_cnt_reg <= 8'd0;
      end else if (frame_err && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign COMMAND             = command_reg;
  assign FRAME_VALID         = frame_valid_reg;
  assign BUS_INTERRUPT_RAISE = irq_reg;

endmodule
